spi_responder: RTL and testbench

- Synthesizable SPI responder (slave) for mode 0 (CPOL=0, CPHA=0), MSB first. It is the far end of the SPI initiator modelled by the spi interface package.
- Oversamples sck/sel_n/mosi in the system clock domain and deserializes received words onto a valid/ready port.
- Serializes transmit words taken from a one-entry holding register.
- Used as the reference DUT endpoint in spi emulation benches.

---
 rtl/spi_responder.sv | 180 ++++++++++++++++++
 tb/tb_spi_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI mode 0 responder (CPOL=0, CPHA=0, MSB first).
// The SPI pins are oversampled in the clk domain. Received words leave on a
// valid/ready port. Transmit words enter through a one-entry holding register.
//
// Handshakes (both ports use the same rule): a transfer happens on a rising
// clk edge where valid && ready. The source holds valid and data stable until
// that edge. The sink may raise or drop ready at any time.
//   rx: rx_valid stays high until taken. If a word completes while a word is
//       still pending and not being taken, the new word is dropped and
//       rx_overrun pulses.
//   tx: tx_ready is high while the holding register is empty. At each word
//       commit the register is drained. If it is empty at commit,
//       TX_IDLE_WORD is sent instead and tx_underrun pulses.
// busy is the state view of the FSM: 0 = IDLE, 1 = SHIFT.
module spi_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_i,
  input  logic                  sel_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, sel_sync_q, mosi_sync_q;
  logic                    sck_d_q;
  logic                    sck_s, sel_n_s, mosi_s, sck_rise, sck_fall;
  logic [DATA_WIDTH-1:0]   rx_shift_q, cur_word_q, hold_q;
  logic                    hold_full_q;
  logic [CNT_W-1:0]        rx_cnt_q, tx_cnt_q;
  logic                    shifting, commit, word_done, rx_load, tx_accept;
  logic [DATA_WIDTH-1:0]   rx_word, tx_shifted;
  logic                    miso_d;

  // Synchronize the SPI pins. Keep a delayed copy of sck for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      sel_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_d_q     <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sel_n_s  = sel_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_q;
  assign sck_fall = ~sck_s & sck_d_q;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state. The synchronized select alone moves between states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!sel_n_s) state_d = ST_SHIFT;
      ST_SHIFT: if (sel_n_s)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Deselect takes priority over any sck edge seen in the same cycle.
  assign shifting  = (state_q == ST_SHIFT) && !sel_n_s;
  assign commit    = shifting && sck_rise && (rx_cnt_q == '0);
  assign word_done = shifting && sck_rise && (rx_cnt_q == LAST_BIT);
  assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  assign rx_load   = word_done && (!rx_valid || rx_ready);
  assign tx_accept = tx_valid && !hold_full_q;

  // Bit counters and receive shifter. The counters are cleared whenever the
  // responder is not selected, so a partial word simply vanishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
    end else if (!shifting) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (sck_rise) begin
        rx_shift_q <= rx_word;
        rx_cnt_q   <= (rx_cnt_q == LAST_BIT) ? '0 : rx_cnt_q + CNT_W'(1);
      end
      if (sck_fall) begin
        tx_cnt_q <= (tx_cnt_q == LAST_BIT) ? '0 : tx_cnt_q + CNT_W'(1);
      end
    end
  end

  // Holding register and current transmit word. A commit reads the old
  // holding content before an accept in the same cycle refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cur_word_q  <= '0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= commit && !hold_full_q;
      if (commit) cur_word_q <= hold_full_q ? hold_q : TX_IDLE_WORD;
      if (tx_accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (commit) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // Receive output port. A new word is loaded or dropped. The handshake clears valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= word_done && rx_valid && !rx_ready;
      if (rx_load) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // MISO source. Before the first falling edge of a word, show the MSB of what
  // the next commit will take. After that, walk through the committed word.
  always_comb begin
    tx_shifted = cur_word_q << tx_cnt_q;
    miso_d     = 1'b1;
    if (state_q == ST_SHIFT) begin
      if (tx_cnt_q == '0)
        miso_d = hold_full_q ? hold_q[DATA_WIDTH-1] : TX_IDLE_WORD[DATA_WIDTH-1];
      else
        miso_d = tx_shifted[DATA_WIDTH-1];
    end
  end

  // Registered MISO pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso_o <= 1'b1;
    else     miso_o <= miso_d;
  end

  assign miso_oe_o = !sel_n_s;
  assign tx_ready  = !hold_full_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: an initiator task drives SPI windows while a
// word-level model predicts the MISO words, the received words, and the flag pulses.
`timescale 1ns/1ps
module tb_spi_responder;

  localparam int W = 8;
  localparam int SYNC = 2;
  localparam logic [W-1:0] IDLE_WORD = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck_i, sel_n_i, mosi_i;
  logic         miso_o, miso_oe_o;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_ready;
  logic         rx_overrun, tx_underrun, busy;

  spi_responder #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC), .TX_IDLE_WORD(IDLE_WORD)) dut (
    .clk(clk), .rst(rst), .sck_i(sck_i), .sel_n_i(sel_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_hold;
  bit           model_hold_full = 0;
  bit           model_rx_held = 0;
  int           exp_und = 0, exp_ovr = 0, und_cnt = 0, ovr_cnt = 0;

  // window description consumed by spi_window
  logic [W-1:0] win_words[4];
  int           n_words;
  int           partial_bits;
  bit           keep_sel;
  int           mid_tx;
  int           half;

  // scoreboard: sample after the negedge where the driver has settled inputs
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (tx_underrun) und_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("rx_unexpected_word", 32'(rx_valid), 32'd0);
        else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver: load the holding register (only called when the model says empty)
  task automatic tx_write(input logic [W-1:0] val);
    @(negedge clk);
    check("tx_ready_before_write", 32'(tx_ready), 32'(!model_hold_full));
    tx_data  = val;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    model_hold      = val;
    model_hold_full = 1;
  endtask

  // driver: one chip-select window acting as a mode 0 initiator
  task automatic spi_window();
    logic [W-1:0] exp_miso, got_miso;
    int  nb, lat;
    bit  seen, measure;
    exp_miso = '0;
    @(negedge clk);
    sel_n_i = 1'b0;
    sck_i   = 1'b0;
    repeat (half) @(negedge clk);
    for (int w = 0; w < n_words; w++) begin
      nb = (partial_bits > 0) ? partial_bits : W;
      got_miso = '0;
      for (int b = 0; b < nb; b++) begin
        mosi_i = win_words[w][W-1-b];
        if (w == 0 && b == 3 && mid_tx >= 0) tx_write(W'(mid_tx));
        repeat (half) @(negedge clk);
        if (w == 0 && b == 1) begin
          check("busy_in_window", 32'(busy), 32'd1);
          check("miso_oe_in_window", 32'(miso_oe_o), 32'd1);
          check("tx_ready_after_commit", 32'(tx_ready), 32'(!model_hold_full));
        end
        got_miso = {got_miso[W-2:0], miso_o};
        if (b == 0) begin
          exp_miso = model_hold_full ? model_hold : IDLE_WORD;
          if (!model_hold_full) exp_und++;
          model_hold_full = 0;
        end
        measure = 0;
        if (b == W - 1) begin
          if (rx_ready) begin
            exp_q.push_back(win_words[w]);
            measure = 1;
          end else if (!model_rx_held) begin
            exp_q.push_back(win_words[w]);
            model_rx_held = 1;
          end else begin
            exp_ovr++;
          end
        end
        sck_i = 1'b1;
        seen = 0;
        lat = 0;
        for (int c = 1; c <= half; c++) begin
          @(negedge clk);
          if (!seen && rx_valid) begin
            seen = 1;
            lat = c;
          end
        end
        if (measure) check("rx_latency", 32'(lat), 32'(SYNC + 1));
        sck_i = 1'b0;
      end
      if (nb == W) check("miso_word", 32'(got_miso), 32'(exp_miso));
    end
    repeat (half) @(negedge clk);
    if (!keep_sel) begin
      sel_n_i = 1'b1;
      repeat (2 * half) @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("miso_oe_idle", 32'(miso_oe_o), 32'd0);
      check("miso_idle", 32'(miso_o), 32'd1);
      check("tx_ready_idle", 32'(tx_ready), 32'(!model_hold_full));
    end
  endtask

  task automatic set_window(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1);
    n_words = n;
    win_words[0] = w0;
    win_words[1] = w1;
    partial_bits = 0;
    keep_sel = 0;
    mid_tx = -1;
  endtask

  task automatic check_flags();
    check("tx_underrun_count", 32'(und_cnt), 32'(exp_und));
    check("rx_overrun_count", 32'(ovr_cnt), 32'(exp_ovr));
    check("rx_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, 32'(miso_o), 32'd1);
    check({tag, "_miso_oe"}, 32'(miso_oe_o), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_flags"}, {30'd0, rx_overrun, tx_underrun}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // main sequence
  initial begin
    rst = 1'b1; sck_i = 1'b0; sel_n_i = 1'b1; mosi_i = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    half = 6;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // preloaded word, single received word
    tx_write(8'hA5);
    set_window(1, 8'h3C, 8'h00);
    spi_window();
    check_flags();

    // two words in one window, refill during word 1
    tx_write(8'h11);
    set_window(2, 8'h80, 8'h01);
    mid_tx = 'h22;
    spi_window();
    check_flags();

    // nothing preloaded: idle word and one underrun
    set_window(1, 8'h55, 8'h00);
    spi_window();
    check_flags();

    // consumer stalled: second word dropped
    rx_ready = 1'b0;
    set_window(2, 8'hAA, 8'hBB);
    spi_window();
    check("stalled_rx_valid", 32'(rx_valid), 32'd1);
    check("stalled_rx_data", 32'(rx_data), 32'(exp_q[0]));
    check("rx_overrun_count_stalled", 32'(ovr_cnt), 32'(exp_ovr));
    rx_ready = 1'b1;
    model_rx_held = 0;
    repeat (4) @(negedge clk);
    check_flags();

    // partial window is discarded, then a full word
    set_window(1, 8'hE7, 8'h00);
    partial_bits = 3;
    spi_window();
    check("partial_no_rx_valid", 32'(rx_valid), 32'd0);
    set_window(1, 8'hC3, 8'h00);
    spi_window();
    check_flags();

    // asynchronous reset in the middle of a word with the holding register full
    set_window(1, 8'h96, 8'h00);
    partial_bits = 5;
    keep_sel = 1;
    spi_window();
    tx_write(8'h5A);
    check("tx_ready_full", 32'(tx_ready), 32'd0);
    #3 rst = 1'b1;
    #1 check_reset_values("async_reset");
    sel_n_i = 1'b1;
    model_hold_full = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    set_window(1, 8'h3A, 8'h00);
    spi_window();
    check_flags();

    // randomized windows
    for (int t = 0; t < 8; t++) begin
      half = $urandom_range(4, 7);
      set_window($urandom_range(1, 3), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      win_words[2] = W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1 && !model_hold_full) tx_write(W'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) mid_tx = $urandom_range(0, 255);
      spi_window();
    end
    repeat (10) @(negedge clk);
    check_flags();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
